rect_fill_engine: RTL and testbench

Hardware rectangle-fill stage for the 160x120, 3-bit-colour frame-buffer path. Sits directly upstream of `vga_core`, in parallel with or in place of the screen-drawing FSM. It accepts one rectangle command per start pulse, clips it to the screen, and streams one pixel write per clock on `x`/`y`/`color`/`plot` in raster order. A start/busy/done handshake lets a controller chain clears, boxes and sprites.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/rect_clip.sv | 43 ++++
 rtl/rect_fill_engine.sv | 154 +++++++++++++++
 tb/tb_rect_fill_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 160x120, 3-bit-colour frame-buffer path.
//   SCREEN_W / SCREEN_H : visible screen size in pixels
//   XW / YW             : x / y coordinate widths
//   color_t             : 3-bit RGB pixel colour
//   rect_state_t        : rectangle-fill FSM states
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int XW       = 8;
    localparam int YW       = 7;

    typedef logic [2:0] color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } rect_state_t;

endpackage

// File: rtl/rect_clip.sv
// -----------------------------------------------------------------------------
// rect_clip
// Combinational clipping of a rectangle command against the visible screen.
// Shared by the rectangle, line and sprite engines.
//   x0_i, y0_i   : top-left corner
//   w_i, h_i     : width / height in pixels (0 = empty)
//   x_end_o      : last column to draw, min(x0+w-1, SCREEN_W-1)
//   y_end_o      : last row to draw,    min(y0+h-1, SCREEN_H-1)
//   empty_o      : nothing of the rectangle is visible
// -----------------------------------------------------------------------------
module rect_clip #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H,
    parameter int XW       = vga_pkg::XW,
    parameter int YW       = vga_pkg::YW
) (
    input  logic [XW-1:0] x0_i,
    input  logic [YW-1:0] y0_i,
    input  logic [XW-1:0] w_i,
    input  logic [YW-1:0] h_i,
    output logic [XW-1:0] x_end_o,
    output logic [YW-1:0] y_end_o,
    output logic          empty_o
);

    localparam logic [XW:0] X_LAST = (XW+1)'(SCREEN_W - 1);
    localparam logic [YW:0] Y_LAST = (YW+1)'(SCREEN_H - 1);

    // One extra bit so x0+w-1 never wraps; the w==0 / h==0 underflow case
    // is irrelevant because it is flagged empty.
    logic [XW:0] x_sum;
    logic [YW:0] y_sum;

    assign x_sum = {1'b0, x0_i} + {1'b0, w_i} - (XW+1)'(1);
    assign y_sum = {1'b0, y0_i} + {1'b0, h_i} - (YW+1)'(1);

    assign x_end_o = (x_sum > X_LAST) ? X_LAST[XW-1:0] : x_sum[XW-1:0];
    assign y_end_o = (y_sum > Y_LAST) ? Y_LAST[YW-1:0] : y_sum[YW-1:0];

    assign empty_o = (w_i == '0) || (h_i == '0) ||
                     ({1'b0, x0_i} > X_LAST) || ({1'b0, y0_i} > Y_LAST);

endmodule

// File: rtl/rect_fill_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_engine
// Accepts one rectangle command per start pulse, clips it to the screen and
// streams one pixel write per clock in raster order towards vga_core.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : command strobe, sampled only in IDLE
//   x0, y0, w, h        : rectangle corner and size
//   fill_color          : colour for the whole rectangle
//   abort               : stop the current fill (LOAD or DRAW only)
//   x, y, color, plot   : registered pixel write to vga_core
//   busy                : command in progress
//   done                : one-cycle completion pulse
// -----------------------------------------------------------------------------
module rect_fill_engine #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H,
    parameter int XW       = vga_pkg::XW,
    parameter int YW       = vga_pkg::YW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [2:0]    fill_color,
    input  logic          abort,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    color,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    import vga_pkg::*;

    rect_state_t   state_q, state_d;
    logic [XW-1:0] x0_q, x0_d, w_q, w_d, x_q, x_d;
    logic [YW-1:0] y0_q, y0_d, h_q, h_d, y_q, y_d;
    color_t        color_q, color_d;
    logic          plot_q, plot_d;

    logic [XW-1:0] x_end;
    logic [YW-1:0] y_end;
    logic          empty;

    // The latched command is stable from LOAD to DONE, so the clip results
    // can be used directly without an extra register stage.
    rect_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .XW       (XW),
        .YW       (YW)
    ) u_clip (
        .x0_i    (x0_q),
        .y0_i    (y0_q),
        .w_i     (w_q),
        .h_i     (h_q),
        .x_end_o (x_end),
        .y_end_o (y_end),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        plot_d  = plot_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = w;
                    h_d     = h;
                    color_d = fill_color;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort || empty) begin
                    state_d = DONE;
                end else begin
                    x_d     = x0_q;
                    y_d     = y0_q;
                    plot_d  = 1'b1;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // The pixel on the outputs this cycle is written regardless;
                // abort only prevents the following ones.
                if (abort) begin
                    plot_d  = 1'b0;
                    state_d = DONE;
                end else if (x_q < x_end) begin
                    x_d = x_q + XW'(1);
                end else if (y_q < y_end) begin
                    x_d = x0_q;
                    y_d = y_q + YW'(1);
                end else begin
                    plot_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                plot_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign plot  = plot_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_rect_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_fill_engine
// Directed bench for rect_fill_engine. Inputs change and outputs are sampled
// on the falling clock edge; k counts falling edges after the start edge, so
// k=n shows what the rising edge T+n samples.
// -----------------------------------------------------------------------------
module tb_rect_fill_engine;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       start      = 1'b0;
    logic       abort      = 1'b0;
    logic [7:0] x0         = '0;
    logic [6:0] y0         = '0;
    logic [7:0] w          = '0;
    logic [6:0] h          = '0;
    logic [2:0] fill_color = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    rect_fill_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .fill_color (fill_color),
        .abort      (abort),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one command at the current falling edge and follows it until
    // the cycle after done. Expected values are supplied by the caller.
    task automatic run_cmd(input string name,
                           input int cx0, input int cy0, input int cw, input int ch,
                           input int cc, input int exp_n, input int exp_xe,
                           input int exp_lx, input int exp_ly, input int exp_done,
                           input int abort_k, input int restart_k);
        int   k, n, first_k, last_k, done_k, done_cnt, coord_bad, color_bad;
        int   ex, ey, lx, ly;
        logic busy1, busy_after;
        x0         = cx0[7:0];
        y0         = cy0[6:0];
        w          = cw[7:0];
        h          = ch[6:0];
        fill_color = cc[2:0];
        start      = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        k         = 1;
        n         = 0;
        first_k   = 0;
        last_k    = 0;
        done_k    = 0;
        done_cnt  = 0;
        coord_bad = 0;
        color_bad = 0;
        ex        = cx0;
        ey        = cy0;
        lx        = -1;
        ly        = -1;
        busy1     = busy;
        busy_after = 1'bx;
        while (k <= 20000) begin
            if (plot === 1'b1) begin
                if (n == 0) first_k = k;
                last_k = k;
                n++;
                if (x !== ex[7:0] || y !== ey[6:0]) coord_bad++;
                if (color !== cc[2:0]) color_bad++;
                lx = int'(x);
                ly = int'(y);
                if (ex < exp_xe) ex++;
                else begin
                    ex = cx0;
                    ey++;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
            if (done_k != 0 && k == done_k + 1) begin
                busy_after = busy;
                break;
            end
            abort = (k == abort_k);
            if (k == restart_k) begin
                x0    = 8'd1;
                y0    = 7'd1;
                w     = 8'd1;
                h     = 7'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        abort = 1'b0;
        start = 1'b0;
        chk({name, " busy_in_load"}, busy1, 1);
        chk({name, " plot_count"}, n, exp_n);
        if (exp_n > 0) begin
            chk({name, " first_plot_cycle"}, first_k, 2);
            chk({name, " plot_contiguous"}, last_k - first_k + 1, n);
            chk({name, " last_x"}, lx, exp_lx);
            chk({name, " last_y"}, ly, exp_ly);
        end
        chk({name, " coord_errors"}, coord_bad, 0);
        chk({name, " color_errors"}, color_bad, 0);
        chk({name, " done_cycle"}, done_k, exp_done);
        chk({name, " done_pulses"}, done_cnt, 1);
        chk({name, " busy_after_done"}, busy_after, 0);
        $display("cmd %s: x0=%0d y0=%0d w=%0d h=%0d col=%0d plots=%0d done@T+%0d last=(%0d,%0d)",
                 name, cx0, cy0, cw, ch, cc, n, done_k, lx, ly);
    endtask

    initial begin
        int done_seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset x", x, 0);
        chk("reset y", y, 0);
        chk("reset color", color, 0);
        chk("reset plot", plot, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        $display("reset: x=%0d y=%0d color=%0d plot=%0d busy=%0d done=%0d", x, y, color, plot, busy, done);
        reset = 1'b0;
        @(negedge clk);

        // name, x0, y0, w, h, col, N, x_end, last x, last y, done cycle, abort k, restart k
        run_cmd("box3x2",  10,  20,   3,   2, 4,     6,  12,  12,  21,     8, 0,   0);
        run_cmd("corner", 158, 118,   5,   5, 3,     4, 159, 159, 119,     6, 0,   0);
        run_cmd("w_zero",  50,  50,   0,   4, 1,     0,   0,   0,   0,     2, 0,   0);
        run_cmd("x_off",  200,  10,   3,   3, 2,     0,   0,   0,   0,     2, 0,   0);
        run_cmd("clear",    0,   0, 160, 120, 5, 19200, 159, 159, 119, 19202, 0, 100);
        run_cmd("abort",   30,  40,   4,   4, 6,     3,  33,  32,  40,     5, 4,   0);

        // Asynchronous reset in the middle of a fill
        x0         = 8'd20;
        y0         = 7'd30;
        w          = 8'd4;
        h          = 7'd4;
        fill_color = 3'd7;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset plot", plot, 1);
        chk("pre_reset x", x, 22);
        chk("pre_reset color", color, 7);
        #1 reset = 1'b1;
        #1;
        chk("async_reset x", x, 0);
        chk("async_reset y", y, 0);
        chk("async_reset color", color, 0);
        chk("async_reset plot", plot, 0);
        chk("async_reset busy", busy, 0);
        chk("async_reset done", done, 0);
        $display("async reset mid-draw: x=%0d y=%0d color=%0d plot=%0d busy=%0d done=%0d",
                 x, y, color, plot, busy, done);
        @(negedge clk);
        reset     = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        chk("post_reset idle", done_seen, 0);

        run_cmd("dot",      5,   5,   1,   1, 2,     1,   5,   5,   5,     3, 0,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
